// File: rtl/cnn_mul_rr_sched_14s_8s.sv
// cnn_mul_rr_sched_14s_8s
//
// Round-robin scheduler that time-shares one signed din0_WIDTH x din1_WIDTH
// multiplier among N_REQ requesting engines. One requester is granted per
// cycle; its operands are multiplied in a short pipeline and the full-width
// product is returned with the requester index on a single back-pressurable
// response port.
//
// Optional build macro: CNN_MUL_RR_SCHED_OUTREG_EN
//   defined   -> extra output register stage (latency 3, inflight up to 3)
//   undefined -> outputs driven from the product stage (latency 2)
//
// Ports:
//   ap_clk     in   clock, rising edge
//   ap_rst     in   synchronous active-high reset
//   req_valid  in   [N_REQ]            requester i presents operands
//   req_ready  out  [N_REQ]            requester i accepted this cycle
//   req_a      in   [N_REQ*din0_WIDTH] operand A, slice i*din0_WIDTH
//   req_b      in   [N_REQ*din1_WIDTH] operand B, slice i*din1_WIDTH
//   rsp_valid  out  response present
//   rsp_ready  in   consumer accepts the response
//   rsp_id     out  [ID_W]             index of the owning requester
//   rsp_p      out  [dout_WIDTH]       signed product a*b
//   inflight   out  [2]                number of valid pipeline stages

module cnn_mul_rr_sched_14s_8s #(
    parameter int N_REQ      = 4,
    parameter int din0_WIDTH = 14,
    parameter int din1_WIDTH = 8,
    parameter int dout_WIDTH = 22,
    localparam int ID_W      = $clog2(N_REQ)
) (
    input  logic                          ap_clk,
    input  logic                          ap_rst,
    input  logic [N_REQ-1:0]              req_valid,
    output logic [N_REQ-1:0]              req_ready,
    input  logic [N_REQ*din0_WIDTH-1:0]   req_a,
    input  logic [N_REQ*din1_WIDTH-1:0]   req_b,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [ID_W-1:0]               rsp_id,
    output logic [dout_WIDTH-1:0]         rsp_p,
    output logic [1:0]                    inflight
);

    function automatic logic signed [dout_WIDTH-1:0] mul_full(
        input logic signed [din0_WIDTH-1:0] a,
        input logic signed [din1_WIDTH-1:0] b
    );
        logic signed [dout_WIDTH-1:0] a_ext;
        logic signed [dout_WIDTH-1:0] b_ext;
        a_ext = dout_WIDTH'(a);
        b_ext = dout_WIDTH'(b);
        return a_ext * b_ext;
    endfunction

    logic                           advance;
    logic                           found;
    logic                           accept;
    logic [ID_W-1:0]                ptr;
    logic [ID_W-1:0]                winner;
    logic [ID_W-1:0]                winner_next;
    logic                           vld_out;

    logic                           vld_p1;
    logic signed [din0_WIDTH-1:0]   a_p1;
    logic signed [din1_WIDTH-1:0]   b_p1;
    logic [ID_W-1:0]                id_p1;

    logic                           vld_p2;
    logic signed [dout_WIDTH-1:0]   prod_p2;
    logic [ID_W-1:0]                id_p2;

`ifdef CNN_MUL_RR_SCHED_OUTREG_EN
    logic                           vld_p3;
    logic signed [dout_WIDTH-1:0]   prod_p3;
    logic [ID_W-1:0]                id_p3;
`endif

    // A held response freezes every stage, bubbles included.
    assign advance = !vld_out || rsp_ready;

    // First valid requester at or after ptr, wrapping.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && req_valid[(int'(ptr) + k) % N_REQ]) begin
                found  = 1'b1;
                winner = ID_W'((int'(ptr) + k) % N_REQ);
            end
        end
    end

    assign accept      = found && advance && !ap_rst;
    assign winner_next = (int'(winner) == N_REQ - 1) ? '0 : winner + 1'b1;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[winner] = 1'b1;
        end
    end

    // Control and output-visible registers (reset)
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            ptr     <= '0;
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
            prod_p2 <= '0;
            id_p2   <= '0;
`ifdef CNN_MUL_RR_SCHED_OUTREG_EN
            vld_p3  <= 1'b0;
            prod_p3 <= '0;
            id_p3   <= '0;
`endif
        end else if (advance) begin
            if (accept) begin
                ptr <= winner_next;
            end
            // stage p1 -> p2: multiply
            vld_p1 <= accept;
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                prod_p2 <= mul_full(a_p1, b_p1);
                id_p2   <= id_p1;
            end
`ifdef CNN_MUL_RR_SCHED_OUTREG_EN
            // stage p2 -> p3: output register
            vld_p3 <= vld_p2;
            if (vld_p2) begin
                prod_p3 <= prod_p2;
                id_p3   <= id_p2;
            end
`endif
        end
    end

    // stage p1: operand capture, only on accept to limit toggling
    always_ff @(posedge ap_clk) begin
        if (accept) begin
            a_p1  <= req_a[int'(winner)*din0_WIDTH +: din0_WIDTH];
            b_p1  <= req_b[int'(winner)*din1_WIDTH +: din1_WIDTH];
            id_p1 <= winner;
        end
    end

`ifdef CNN_MUL_RR_SCHED_OUTREG_EN
    assign vld_out   = vld_p3;
    assign rsp_p     = prod_p3;
    assign rsp_id    = id_p3;
    assign inflight  = {1'b0, vld_p1} + {1'b0, vld_p2} + {1'b0, vld_p3};
`else
    assign vld_out   = vld_p2;
    assign rsp_p     = prod_p2;
    assign rsp_id    = id_p2;
    assign inflight  = {1'b0, vld_p1} + {1'b0, vld_p2};
`endif

    assign rsp_valid = vld_out;

endmodule

// File: tb/tb_cnn_mul_rr_sched_14s_8s.sv
// Testbench for cnn_mul_rr_sched_14s_8s (N_REQ=4, 14x8 -> 22).
// A reference model of the round-robin pointer and pipeline occupancy runs
// on every falling edge; expected products are queued at accept time and
// popped when the response handshake occurs. Scenario tasks add targeted
// checks with hand-derived constants.

module tb_cnn_mul_rr_sched_14s_8s;

    localparam int N = 4;
`ifdef CNN_MUL_RR_SCHED_OUTREG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [55:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [21:0] rsp_p;
    logic [1:0]  inflight;

    cnn_mul_rr_sched_14s_8s dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_p     (rsp_p),
        .inflight  (inflight)
    );

    always #5 ap_clk = ~ap_clk;

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;

    typedef struct {
        int id;
        int p;
    } exp_t;

    exp_t       sbq[$];
    int         mptr = 0;
    logic [2:0] mv   = 3'b000;

    int         m_w;
    int         m_cnt;
    logic       m_adv;
    logic       m_expv;
    logic [3:0] m_rdy;
    exp_t       m_e;

    function automatic int rr_pick(input logic [3:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // Reference model + scoreboard
    always @(negedge ap_clk) begin
        if (mon_en) begin
            m_expv = mv[LAT-1];
            m_adv  = !m_expv || rsp_ready;
            m_w    = rr_pick(req_valid, mptr);
            m_rdy  = (!ap_rst && m_adv && m_w >= 0) ? 4'(1 << m_w) : 4'b0000;
            checks++;
            if (req_ready !== m_rdy) begin
                failures++;
                $display("FAIL sb_req_ready got=%b want=%b t=%0t", req_ready, m_rdy, $time);
            end
            checks++;
            if (rsp_valid !== m_expv) begin
                failures++;
                $display("FAIL sb_rsp_valid got=%b want=%b t=%0t", rsp_valid, m_expv, $time);
            end
            m_cnt = 0;
            for (int k = 0; k < LAT; k++) m_cnt += int'(mv[k]);
            checks++;
            if (inflight !== 2'(m_cnt)) begin
                failures++;
                $display("FAIL sb_inflight got=%0d want=%0d t=%0t", inflight, m_cnt, $time);
            end
            if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
                checks++;
                if (sbq.size() == 0) begin
                    failures++;
                    $display("FAIL sb_spurious got id=%0d p=%0d want=none t=%0t", rsp_id, $signed(rsp_p), $time);
                end else begin
                    m_e = sbq.pop_front();
                    if (rsp_id !== 2'(m_e.id) || rsp_p !== 22'(m_e.p)) begin
                        failures++;
                        $display("FAIL sb_rsp got id=%0d p=%0d want id=%0d p=%0d t=%0t",
                                 rsp_id, $signed(rsp_p), m_e.id, m_e.p, $time);
                    end
                end
            end
            if (ap_rst) begin
                mptr = 0;
                mv   = 3'b000;
                sbq.delete();
            end else if (m_adv) begin
                mv = {mv[1:0], (m_w >= 0)};
                if (m_w >= 0) begin
                    m_e.id = m_w;
                    m_e.p  = $signed(req_a[m_w*14 +: 14]) * $signed(req_b[m_w*8 +: 8]);
                    sbq.push_back(m_e);
                    mptr = (m_w + 1) % N;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic set_req(input int i, input int a, input int b);
        req_a[i*14 +: 14] = 14'(a);
        req_b[i*8 +: 8]   = 8'(b);
    endtask

    task automatic do_reset();
        step();
        ap_rst    = 1'b1;
        req_valid = 4'b0000;
        rsp_ready = 1'b1;
        step();
        ap_rst    = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int c = 0; c < n; c++) begin
            step();
            req_valid = 4'b0000;
            rsp_ready = 1'b1;
        end
        @(negedge ap_clk);
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL drain_empty got=%0d want=0", sbq.size());
        end
    endtask

    task automatic test_reset();
        ap_rst    = 1'b1;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        req_a     = '0;
        req_b     = '0;
        @(posedge ap_clk);
        #1;
        mon_en = 1'b1;
        @(negedge ap_clk);
        checks++;
        if (req_ready !== 4'b0000 || rsp_valid !== 1'b0 || inflight !== 2'd0 ||
            rsp_p !== 22'd0 || rsp_id !== 2'd0) begin
            failures++;
            $display("FAIL reset_state got rdy=%b v=%b inf=%0d p=%0d id=%0d want 0000/0/0/0/0",
                     req_ready, rsp_valid, inflight, rsp_p, rsp_id);
        end
        step();
        ap_rst    = 1'b0;
        req_valid = 4'b0000;
    endtask

    task automatic test_single();
        step();
        req_valid = 4'b0010;
        set_req(1, -8192, -128);
        @(negedge ap_clk);
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++;
            $display("FAIL single_grant got=%b want=0010", req_ready);
        end
        for (int c = 1; c <= LAT; c++) begin
            step();
            req_valid = 4'b0000;
            @(negedge ap_clk);
            checks++;
            if (c < LAT) begin
                if (rsp_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL single_early got=%b want=0 c=%0d", rsp_valid, c);
                end
            end else if (rsp_valid !== 1'b1 || rsp_p !== 22'd1048576 || rsp_id !== 2'd1) begin
                failures++;
                $display("FAIL single_rsp got v=%b p=%0d id=%0d want v=1 p=1048576 id=1",
                         rsp_valid, $signed(rsp_p), rsp_id);
            end
        end
        drain(2);
    endtask

    task automatic test_contention();
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, i + 1, 3);
        for (int c = 0; c < 8 + LAT; c++) begin
            step();
            req_valid = (c < 8) ? 4'b1111 : 4'b0000;
            @(negedge ap_clk);
            if (c < 8) begin
                checks++;
                if (req_ready !== 4'(1 << (c % 4))) begin
                    failures++;
                    $display("FAIL contention_grant got=%b want=%b c=%0d", req_ready, 4'(1 << (c % 4)), c);
                end
            end
            if (c >= LAT) begin
                checks++;
                if (rsp_valid !== 1'b1 || rsp_id !== 2'((c - LAT) % 4) ||
                    rsp_p !== 22'(3 * ((c - LAT) % 4 + 1))) begin
                    failures++;
                    $display("FAIL contention_rsp got v=%b id=%0d p=%0d want v=1 id=%0d p=%0d",
                             rsp_valid, rsp_id, $signed(rsp_p), (c - LAT) % 4, 3 * ((c - LAT) % 4 + 1));
                end
            end
        end
        drain(LAT);
    endtask

    task automatic test_back_to_back();
        logic [21:0] held_p;
        logic [1:0]  held_id;
        held_p  = '0;
        held_id = '0;
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, -1000 * (i + 1) + 7, -(i + 2));
        for (int c = 0; c < 12; c++) begin
            step();
            req_valid = (c < 10) ? 4'b1111 : 4'b0000;
            rsp_ready = !(c >= 4 && c < 7);
            @(negedge ap_clk);
            if (c >= 4 && c < 7) begin
                checks++;
                if (req_ready !== 4'b0000 || rsp_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL stall_ready got rdy=%b v=%b want rdy=0000 v=1 c=%0d", req_ready, rsp_valid, c);
                end
                if (c == 4) begin
                    held_p  = rsp_p;
                    held_id = rsp_id;
                end else begin
                    checks++;
                    if (rsp_p !== held_p || rsp_id !== held_id) begin
                        failures++;
                        $display("FAIL stall_hold got p=%0d id=%0d want p=%0d id=%0d",
                                 $signed(rsp_p), rsp_id, $signed(held_p), held_id);
                    end
                end
            end
        end
        drain(LAT + 2);
    endtask

    task automatic test_wrap();
        logic [3:0] want;
        do_reset();
        set_req(0, 5, 5);
        set_req(2, -7, 9);
        step();
        req_valid = 4'b0100;
        @(negedge ap_clk);
        checks++;
        if (req_ready !== 4'b0100) begin
            failures++;
            $display("FAIL wrap_setup got=%b want=0100", req_ready);
        end
        for (int c = 0; c < 3; c++) begin
            step();
            req_valid = 4'b0101;
            want = (c == 1) ? 4'b0100 : 4'b0001;
            @(negedge ap_clk);
            checks++;
            if (req_ready !== want) begin
                failures++;
                $display("FAIL wrap_grant got=%b want=%b c=%0d", req_ready, want, c);
            end
        end
        drain(LAT + 1);
    endtask

    task automatic test_extremes();
        int a_t[3];
        int b_t[3];
        int p_t[3];
        a_t = '{8191, -8192, 0};
        b_t = '{127, 127, 55};
        p_t = '{1040257, -1040384, 0};
        for (int c = 0; c < 3 + LAT; c++) begin
            step();
            if (c < 3) begin
                req_valid = 4'b0001;
                set_req(0, a_t[c], b_t[c]);
            end else begin
                req_valid = 4'b0000;
            end
            @(negedge ap_clk);
            if (c < 3) begin
                checks++;
                if (req_ready !== 4'b0001) begin
                    failures++;
                    $display("FAIL extreme_grant got=%b want=0001 c=%0d", req_ready, c);
                end
            end
            if (c >= LAT) begin
                checks++;
                if (rsp_valid !== 1'b1 || rsp_p !== 22'(p_t[c - LAT])) begin
                    failures++;
                    $display("FAIL extreme_rsp got v=%b p=%0d want v=1 p=%0d",
                             rsp_valid, $signed(rsp_p), p_t[c - LAT]);
                end
            end
        end
        drain(2);
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 100 + i, -3);
        for (int c = 0; c < 2; c++) begin
            step();
            req_valid = 4'b1111;
            @(negedge ap_clk);
        end
        step();
        ap_rst = 1'b1;
        @(negedge ap_clk);
        checks++;
        if (inflight !== 2'd2 || req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL rstmid_pre got inf=%0d rdy=%b want inf=2 rdy=0000", inflight, req_ready);
        end
        step();
        ap_rst = 1'b0;
        @(negedge ap_clk);
        checks++;
        if (rsp_valid !== 1'b0 || inflight !== 2'd0 || req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL rstmid_post got v=%b inf=%0d rdy=%b want v=0 inf=0 rdy=0001",
                     rsp_valid, inflight, req_ready);
        end
        drain(LAT + 1);
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_back_to_back();
        test_wrap();
        test_extremes();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
